// File: rtl/qlf_k6n10_seg_adder.sv
// Pipelined wide adder/subtractor: one SEG-bit carry-chain slice per stage, registered inter-slice carry.
// Optional signed-overflow output is enabled by defining QLF_SEG_ADDER_OVF_EN.
module qlf_k6n10_seg_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] x,
    output logic             co
`ifdef QLF_SEG_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSEG = (WIDTH + SEG - 1) / SEG;

    logic             adv;
    logic [WIDTH-1:0] bb;

    assign bb       = bi ? ~b : b;
    assign in_ready = ~out_valid | out_ready;
    assign adv      = in_ready;

    // Stage k keeps only what is still needed downstream: the operand bits above
    // its slice (skew) and the sum bits produced so far (deskew).
    for (genvar k = 0; k < NSEG; k++) begin : stg
        localparam int LO = k * SEG;
        localparam int SW = (k == NSEG - 1) ? WIDTH - LO : SEG;
        localparam int HI = LO + SW;

        logic [WIDTH-LO-1:0] op_a;
        logic [WIDTH-LO-1:0] op_b;
        logic [WIDTH-1:0]    x_in;
        logic                c_in;
        logic                v_in;
        logic [SW:0]         slice;
        logic [HI-1:0]       s_nxt;

        logic                v_r;
        logic                c_r;
        logic [WIDTH-1:0]    x_r;
        logic [HI-1:0]       s_r;

        if (k == 0) begin : g_head
            assign op_a  = a;
            assign op_b  = bb;
            assign x_in  = a ^ bb;
            assign c_in  = ci;
            assign v_in  = in_valid;
            assign s_nxt = slice[SW-1:0];
        end else begin : g_body
            assign op_a  = stg[k-1].g_fwd.a_r;
            assign op_b  = stg[k-1].g_fwd.b_r;
            assign x_in  = stg[k-1].x_r;
            assign c_in  = stg[k-1].c_r;
            assign v_in  = stg[k-1].v_r;
            assign s_nxt = {slice[SW-1:0], stg[k-1].s_r};
        end

        // slice[SW] is the carry out of the top valid bit, never of padding.
        assign slice = {1'b0, op_a[SW-1:0]} + {1'b0, op_b[SW-1:0]} + {{SW{1'b0}}, c_in};

        // Data only loads with a valid beat, so the output holds through bubbles.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                x_r <= '0;
                s_r <= '0;
            end else if (adv) begin
                v_r <= v_in;
                if (v_in) begin
                    c_r <= slice[SW];
                    x_r <= x_in;
                    s_r <= s_nxt;
                end
            end
        end

        if (k < NSEG - 1) begin : g_fwd
            logic [WIDTH-HI-1:0] a_r;
            logic [WIDTH-HI-1:0] b_r;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv && v_in) begin
                    a_r <= op_a[WIDTH-LO-1:SW];
                    b_r <= op_b[WIDTH-LO-1:SW];
                end
            end
        end
    end

    assign out_valid = stg[NSEG-1].v_r;
    assign y         = stg[NSEG-1].s_r;
    assign x         = stg[NSEG-1].x_r;
    assign co        = stg[NSEG-1].c_r;

`ifdef QLF_SEG_ADDER_OVF_EN
    // Carry into the top bit is a^bb^sum there, i.e. x^y.
    assign ovf = x[WIDTH-1] ^ y[WIDTH-1] ^ co;
`endif

endmodule

// File: tb/tb_qlf_k6n10_seg_adder.sv
// Bench for qlf_k6n10_seg_adder: 64/20 main instance plus 20/20 and 41/20 latency instances.
// Covers QLF_SEG_ADDER_OVF_EN when defined.
module tb_qlf_k6n10_seg_adder;

    localparam int W  = 64;
    localparam int S  = 20;
    localparam int NS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, in_valid, in_ready, ci, bi, out_valid, out_ready, co;
    logic [W-1:0]  a, b, y, x;
`ifdef QLF_SEG_ADDER_OVF_EN
    logic          ovf, ovf20, ovf41;
`endif

    logic          s_valid;
    logic          rdy20, v20, co20, rdy41, v41, co41;
    logic [19:0]   a20, b20, y20, x20;
    logic [40:0]   a41, b41, y41, x41;

    qlf_k6n10_seg_adder #(.WIDTH(W), .SEG(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .x(x), .co(co)
`ifdef QLF_SEG_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    qlf_k6n10_seg_adder #(.WIDTH(20), .SEG(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(rdy20),
        .a(a20), .b(b20), .ci(1'b0), .bi(1'b0), .out_valid(v20), .out_ready(1'b1),
        .y(y20), .x(x20), .co(co20)
`ifdef QLF_SEG_ADDER_OVF_EN
        , .ovf(ovf20)
`endif
    );

    qlf_k6n10_seg_adder #(.WIDTH(41), .SEG(20)) dut41 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(rdy41),
        .a(a41), .b(b41), .ci(1'b0), .bi(1'b0), .out_valid(v41), .out_ready(1'b1),
        .y(y41), .x(x41), .co(co41)
`ifdef QLF_SEG_ADDER_OVF_EN
        , .ovf(ovf41)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] a, b;
        logic        ci, bi;
        logic [63:0] ey, ex;
        logic        eco;
    } vec_t;

    typedef struct {
        logic [63:0] y, x;
        logic        co, ovf;
    } res_t;

    vec_t vecs [7];
    res_t q [$];
    int   n_emit = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 65-bit unsigned arithmetic and sign-rule overflow.
    function automatic res_t model(input logic [63:0] ma, input logic [63:0] mb,
                                   input logic mci, input logic mbi);
        res_t        r;
        logic [63:0] mbb;
        logic [64:0] full;
        mbb   = mbi ? ~mb : mb;
        full  = {1'b0, ma} + {1'b0, mbb} + 65'(mci);
        r.y   = full[63:0];
        r.co  = full[64];
        r.x   = ma ^ mbb;
        r.ovf = (ma[63] == mbb[63]) && (r.y[63] != ma[63]);
        return r;
    endfunction

    // Scoreboard and output-stability monitor, sampled mid-cycle.
    initial begin
        logic        prev_stall, prev_rstn, last_co;
        logic [63:0] last_y, last_x;
        res_t        e;
        prev_stall = 1'b0;
        prev_rstn  = 1'b0;
        last_y = '0; last_x = '0; last_co = 1'b0;
        forever begin
            @(negedge clk);
            if (!prev_rstn) begin
                last_y = '0; last_x = '0; last_co = 1'b0;
            end
            if (prev_stall && prev_rstn) begin
                checks++;
                if (!out_valid || y !== last_y || x !== last_x || co !== last_co) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b y=%h co=%b expected v=1 y=%h co=%b",
                             out_valid, y, co, last_y, last_co);
                end
            end
            if (out_valid) begin
                last_y = y; last_x = x; last_co = co;
            end else begin
                checks++;
                if (y !== last_y || x !== last_x || co !== last_co) begin
                    errors++;
                    $display("FAIL bubble_hold: got y=%h co=%b expected y=%h co=%b", y, co, last_y, last_co);
                end
            end
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (!rst_n) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_emit++;
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra: got y=%h expected no beat", y);
                    end else begin
                        e = q.pop_front();
                        if (y !== e.y || x !== e.x || co !== e.co
`ifdef QLF_SEG_ADDER_OVF_EN
                            || ovf !== e.ovf
`endif
                           ) begin
                            errors++;
                            $display("FAIL sb_result: got y=%h x=%h co=%b expected y=%h x=%h co=%b",
                                     y, x, co, e.y, e.x, e.co);
                        end
                    end
                end
                if (in_valid && in_ready) q.push_back(model(a, b, ci, bi));
            end
            prev_stall = out_valid && !out_ready;
            prev_rstn  = rst_n;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic rand_beat();
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        ci = 1'($urandom);
        bi = 1'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        bit got;
        @(posedge clk); #1;
        a = v.a; b = v.b; ci = v.ci; bi = v.bi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; got = 0;
        while (lat <= 12) begin
            @(negedge clk);
            if (out_valid) begin got = 1; break; end
            @(posedge clk);
            lat++;
        end
        chk("vec_latency", got ? 64'(lat) : 64'(0), 64'(NS));
        chk("vec_y", y, v.ey);
        chk("vec_x", x, v.ex);
        chk("vec_co", 64'(co), 64'(v.eco));
    endtask

    initial begin
        int  sent, cyc, n0;
        bit  acc;
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[1] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[2] = '{64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1};
        vecs[3] = '{64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
        vecs[5] = '{64'h0000_0000_000F_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0010_0000,
                    64'h0000_0000_000F_FFFE, 1'b0};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; s_valid = 1'b0;
        rand_beat();
        a20 = '0; b20 = '0; a41 = '0; b41 = '0;

        // Reset held two cycles with a beat presented.
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_y", y, 64'd0);
            chk("rst_co", 64'(co), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (NS + 1) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(out_valid), 64'd0);
        end
        chk("post_rst_x", x, 64'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Back-to-back subtract pair.
        @(posedge clk); #1;
        a = 64'd5; b = 64'd7; ci = 1'b1; bi = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 64'd7; b = 64'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_v1", 64'(out_valid), 64'd1);
        chk("b2b_y1", y, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("b2b_co1", 64'(co), 64'd0);
        @(negedge clk);
        chk("b2b_v2", 64'(out_valid), 64'd1);
        chk("b2b_y2", y, 64'd2);
        chk("b2b_co2", 64'(co), 64'd1);
        repeat (2) @(posedge clk);

        // Backpressure: out_ready 1,0,0,1 repeating, 10 random beats.
        n0 = n_emit; sent = 0; cyc = 0;
        @(posedge clk); #1;
        rand_beat(); in_valid = 1'b1;
        while (cyc < 200 && !(sent == 10 && q.size() == 0)) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 10) rand_beat(); else in_valid = 1'b0;
            end
            cyc++;
        end
        chk("bp_done", 64'(cyc < 200), 64'd1);
        chk("bp_emits", 64'(n_emit - n0), 64'd10);

        // Randomized stream with random in_valid and out_ready.
        n0 = n_emit; sent = 0;
        in_valid = 1'($urandom_range(0, 1)); rand_beat();
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_beat();
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (cyc < 20 && q.size() != 0) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand_drain", 64'(q.size()), 64'd0);
        chk("rand_emits", 64'(n_emit - n0), 64'(sent));

        // Reset on the cycle after the third accept.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            rand_beat(); in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_valid", 64'(out_valid), 64'd0);
        end
        run_vec(vecs[2]);

        // Narrow instances: latency 1 and 3.
        @(posedge clk); #1;
        a20 = '1; b20 = 20'd1; a41 = '1; b41 = 41'd1; s_valid = 1'b1;
        @(negedge clk);
        chk("w20_v_c0", 64'(v20), 64'd0);
        chk("w41_v_c0", 64'(v41), 64'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("w20_v_c1", 64'(v20), 64'd1);
        chk("w20_y", 64'(y20), 64'd0);
        chk("w20_x", 64'(x20), 64'hF_FFFE);
        chk("w20_co", 64'(co20), 64'd1);
        chk("w20_rdy", 64'(rdy20), 64'd1);
        chk("w41_v_c1", 64'(v41), 64'd0);
        @(negedge clk);
        chk("w41_v_c2", 64'(v41), 64'd0);
        chk("w20_v_c2", 64'(v20), 64'd0);
        @(negedge clk);
        chk("w41_v_c3", 64'(v41), 64'd1);
        chk("w41_y", 64'(y41), 64'd0);
        chk("w41_x", 64'(x41), 64'h1FF_FFFF_FFFE);
        chk("w41_co", 64'(co41), 64'd1);
        chk("w41_rdy", 64'(rdy41), 64'd1);
`ifdef QLF_SEG_ADDER_OVF_EN
        @(posedge clk); #1;
        a20 = 20'h7_FFFF; b20 = 20'd1; a41 = 41'h0FF_FFFF_FFFF; b41 = 41'd1; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("w20_ovf", 64'(ovf20), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("w41_v_ovf", 64'(v41), 64'd1);
        chk("w41_ovf", 64'(ovf41), 64'd1);
`endif
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qlf_k6n10_seg_adder.md
Name: qlf_k6n10_seg_adder

Overview:
- Pipelined wide adder/subtractor for QLF K6N10 that splits a WIDTH-bit add into SEG-bit slices, one slice per stage, each sized to fit one hard carry-chain run.
- Carry between slices is registered, so no chain crosses a column boundary.
- Consumes the per-bit adder primitive used for $alu mapping, and feeds datapaths that need adds wider than one chain at full clock rate.

Parameters:
- WIDTH, 64, operand and result width in bits (>=1).
- SEG, 20, bits per slice = usable carry-chain length per column (>=1).
- NSEG, derived = ceil(WIDTH/SEG), number of stages and latency in cycles. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A, unsigned bit vector
- b  input  WIDTH  operand B
- ci  input  1  carry-in to bit 0
- bi  input  1  invert B (subtract when ci=1)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- y  output  WIDTH  sum bits
- x  output  WIDTH  a ^ (bi ? ~b : b)
- co  output  1  carry out of bit WIDTH-1

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is synchronous and active-low.
- Reset values (rst_n=0 at a clk edge): all stage valid bits 0, out_valid=0, y=0, x=0, co=0, internal carries 0. Reset mid-operation discards every in-flight beat; no partial result is emitted.
- Operand conditioning at accept: bb = bi ? ~b : b, and x = a ^ bb, both computed at accept. x is carried down the pipe with its beat.
- Stage k (0..NSEG-1) adds slice k = bits [k*SEG +: SEG] of a and bb, plus the carry registered by stage k-1 (stage 0 uses ci).
  - It registers the slice sum and the slice carry-out.
  - The last slice is WIDTH-(NSEG-1)*SEG bits wide; co is the carry out of its top valid bit, not of SEG padding.
- Skew/deskew: a/bb slices for stage k are delayed k cycles; result slices from stage k are delayed NSEG-1-k cycles. All bits of one beat therefore appear on y together.
- Latency: exactly NSEG cycles from accept (in_valid&in_ready) to out_valid when unstalled. WIDTH<=SEG gives NSEG=1, latency 1.
- Throughput: one beat per cycle when out_ready=1.
- Handshake:
  - in_ready = ~out_valid | out_ready, a global stall, registered-free.
  - When stalled, all stage registers, carries and valid bits hold.
  - in_valid with in_ready=0 is not accepted; the source holds a/b/ci/bi.
  - The output is held stable while out_valid & ~out_ready.
  - Accept and emit in the same cycle is legal and sustains full rate.
- Bubbles: an empty stage advances with valid=0. Data in bubble stages is don't-care; y/x/co hold their last emitted values when out_valid=0.
- Arithmetic: y = (a + bb + ci) mod 2^WIDTH, co = bit WIDTH of the full sum, unsigned. Signed interpretation is left to the consumer.

Optional Feature:
- QLF_SEG_ADDER_OVF_EN
- Defined:
  - Adds output port ovf (1 bit) = signed overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, aligned with y.
  - Reset value 0; holds with y under stall.
- Undefined: port absent; no extra logic.

Test Plan:
- WIDTH=64,SEG=20, reset: hold rst_n=0 two cycles with in_valid=1 -> out_valid=0, y=0, co=0 throughout and 1 cycle after release; no output appears from beats presented during reset.
- Carry ripple across all slices: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, ci=1, bi=0 -> after 4 cycles y=0, co=1, x=64'hFFFF_FFFF_FFFF_FFFF.
- Subtract: a=64'd5, b=64'd7, bi=1, ci=1 -> y=64'hFFFF_FFFF_FFFF_FFFE, co=0. Then a=7, b=5 -> y=2, co=1; 4-cycle latency, back-to-back.
- Backpressure: stream 10 random beats with out_ready toggled 1,0,0,1 repeating -> every result matches reference a+bb+ci, in order, no drops or duplicates. y is stable while out_valid&~out_ready, and in_ready=0 exactly in those cycles.
- Reset mid-operation: accept 3 beats, assert rst_n=0 one cycle on the cycle after the 3rd accept -> out_valid stays 0 until new beats are accepted.
- WIDTH=20,SEG=20 and WIDTH=41,SEG=20: a=all-ones, b=1, ci=0 -> latency 1 and 3 respectively, y=0, co=1. With QLF_SEG_ADDER_OVF_EN: a=2^(WIDTH-1)-1, b=1 -> ovf=1.
